// File: rtl/parallel_to_serial_lanes_if.sv
// Word-in / beat-out handshake bundle for parallel_to_serial_lanes.
// master drives words and shift_en; slave is the converter.
interface parallel_to_serial_lanes_if #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned LANES     = 1
);
  logic [DATA_SIZE-1:0] data_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 shift_en;
  logic [LANES-1:0]     data_out;
  logic                 out_valid;
  logic                 last;
  logic                 busy;

  modport master (
    output data_in, in_valid, shift_en,
    input  in_ready, data_out, out_valid, last, busy
  );

  modport slave (
    input  data_in, in_valid, shift_en,
    output in_ready, data_out, out_valid, last, busy
  );
endinterface

// File: rtl/parallel_to_serial_lanes.sv
// Handshaked parallel-to-serial converter: each DATA_SIZE word leaves as DATA_SIZE/LANES beats.
// Define PTS_PRELOAD_EN to add a one-word holding register so words stream without idle gaps.
module parallel_to_serial_lanes #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic                       clk,
  input logic                       rst_n,
  parallel_to_serial_lanes_if.slave bus
);
  localparam int unsigned BEATS = DATA_SIZE / LANES;
  localparam int unsigned CntW  = $clog2(BEATS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BEATS);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] sr_q, sr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [LANES-1:0]     dout_q, dout_d;
  logic                 ov_q, ov_d;
  logic                 last_q, last_d;

  logic                 in_ready;
  logic                 accept;
  logic                 final_beat;
  logic [LANES-1:0]     beat;
  logic [DATA_SIZE-1:0] sr_shifted;

  // Emitting end of the register and the zero-filled shift toward it.
  if (MSB_FIRST) begin : g_msb_first
    assign beat       = sr_q[DATA_SIZE-1 -: LANES];
    assign sr_shifted = sr_q << LANES;
  end else begin : g_lsb_first
    assign beat       = sr_q[LANES-1:0];
    assign sr_shifted = sr_q >> LANES;
  end

`ifdef PTS_PRELOAD_EN
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 full_q, full_d;

  assign in_ready = rst_n && ((state_q == StIdle) || !full_q);
`else
  assign in_ready = rst_n && (state_q == StIdle);
`endif

  assign accept     = bus.in_valid && in_ready;
  assign final_beat = (state_q == StShift) && bus.shift_en && (cnt_q == CntOne);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ov_d    = 1'b0;
    last_d  = 1'b0;
`ifdef PTS_PRELOAD_EN
    hold_d  = hold_q;
    full_d  = full_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d    = bus.data_in;
          cnt_d   = CntFull;
          state_d = StShift;
        end
      end

      StShift: begin
        if (bus.shift_en) begin
          dout_d = beat;
          ov_d   = 1'b1;
          last_d = final_beat;
          sr_d   = sr_shifted;
          cnt_d  = cnt_q - 1'b1;
        end
`ifdef PTS_PRELOAD_EN
        // On the final beat the next word comes from the holding register first,
        // otherwise straight from the input; a word accepted mid-word is parked.
        if (final_beat) begin
          if (full_q) begin
            sr_d   = hold_q;
            cnt_d  = CntFull;
            full_d = 1'b0;
          end else if (accept) begin
            sr_d  = bus.data_in;
            cnt_d = CntFull;
          end else begin
            state_d = StIdle;
          end
        end else if (accept) begin
          hold_d = bus.data_in;
          full_d = 1'b1;
        end
`else
        if (final_beat) begin
          state_d = StIdle;
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
      last_q  <= last_d;
    end
  end

`ifdef PTS_PRELOAD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.data_out  = dout_q;
  assign bus.out_valid = ov_q;
  assign bus.last      = last_q;
  assign bus.busy      = (state_q == StShift);

endmodule

// File: tb/tb_parallel_to_serial_lanes.sv
// Bench for parallel_to_serial_lanes: five configurations run side by side against a
// word/beat-index reference model, plus literal beat sequences for the directed words.
module tb_parallel_to_serial_lanes;
  localparam int N = 5;
`ifdef PTS_PRELOAD_EN
  localparam bit Pre = 1'b1;
`else
  localparam bit Pre = 1'b0;
`endif

  function automatic int ds_of(int k);
    case (k)
      1, 2:    return 64;
      default: return 8;
    endcase
  endfunction

  function automatic int ln_of(int k);
    case (k)
      0:       return 1;
      1, 2:    return 4;
      3:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int msb_of(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int beats(int k);
    return ds_of(k) / ln_of(k);
  endfunction

  logic clk;
  logic rst_n;
  logic [N-1:0][63:0] din;
  logic [N-1:0]       iv, se;
  logic [N-1:0][63:0] dout;
  logic [N-1:0]       ov, lst, rdy, bsy;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = ds_of(g);
    localparam int L = ln_of(g);
    parallel_to_serial_lanes_if #(.DATA_SIZE(D), .LANES(L)) ifc ();
    assign ifc.data_in  = din[g][D-1:0];
    assign ifc.in_valid = iv[g];
    assign ifc.shift_en = se[g];
    assign dout[g]      = 64'(ifc.data_out);
    assign ov[g]        = ifc.out_valid;
    assign lst[g]       = ifc.last;
    assign rdy[g]       = ifc.in_ready;
    assign bsy[g]       = ifc.busy;
    parallel_to_serial_lanes #(
      .DATA_SIZE(D),
      .LANES    (L),
      .MSB_FIRST(msb_of(g) != 0)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the current word, the index of the next beat, and an optional parked word.
  logic [63:0] m_word [N];
  logic [63:0] m_hold [N];
  int          m_idx  [N];
  bit          m_busy [N];
  bit          m_full [N];
  bit          m_acc  [N];
  logic [63:0] e_dout [N];
  bit          e_ov   [N];
  bit          e_last [N];

  function automatic logic [63:0] dmask(int k);
    return (ds_of(k) == 64) ? '1 : ((64'd1 << ds_of(k)) - 64'd1);
  endfunction

  function automatic logic [63:0] beat_of(int k, logic [63:0] w, int i);
    logic [63:0] m;
    m = (64'd1 << ln_of(k)) - 64'd1;
    if (msb_of(k) != 0) return (w >> (ds_of(k) - (i + 1) * ln_of(k))) & m;
    return (w >> (i * ln_of(k))) & m;
  endfunction

  function automatic bit e_rdy(int k);
    return rst_n && (!m_busy[k] || (Pre && !m_full[k]));
  endfunction

  function automatic void model_reset(int k);
    m_busy[k] = 1'b0;
    m_full[k] = 1'b0;
    m_acc[k]  = 1'b0;
    m_idx[k]  = 0;
    e_dout[k] = '0;
    e_ov[k]   = 1'b0;
    e_last[k] = 1'b0;
  endfunction

  function automatic void model_step(int k);
    bit rdy_m, acc, fin;
    rdy_m = !m_busy[k] || (Pre && !m_full[k]);
    acc = iv[k] && rdy_m;
    m_acc[k] = acc;
    e_ov[k] = 1'b0;
    e_last[k] = 1'b0;
    if (!m_busy[k]) begin
      if (acc) begin
        m_busy[k] = 1'b1;
        m_word[k] = din[k] & dmask(k);
        m_idx[k]  = 0;
      end
    end else begin
      fin = se[k] && (m_idx[k] == beats(k) - 1);
      if (se[k]) begin
        e_dout[k] = beat_of(k, m_word[k], m_idx[k]);
        e_ov[k]   = 1'b1;
        e_last[k] = fin;
        m_idx[k]++;
      end
      if (fin) begin
        if (m_full[k]) begin
          m_word[k] = m_hold[k];
          m_full[k] = 1'b0;
          m_idx[k]  = 0;
        end else if (acc) begin
          m_word[k] = din[k] & dmask(k);
          m_idx[k]  = 0;
        end else begin
          m_busy[k] = 1'b0;
        end
      end else if (acc) begin
        m_hold[k] = din[k] & dmask(k);
        m_full[k] = 1'b1;
      end
    end
  endfunction

  // Advance model and DUT by one rising edge, then park on the falling edge for sampling.
  task automatic tick();
    for (int k = 0; k < N; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = '0;
    se = '0;
    din = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst_n = 1'b1;
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if ({ov[k], lst[k], rdy[k], bsy[k], dout[k]} !==
            {e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]}) begin
          n_err++;
          $display("FAIL reset dut%0d c%0d: ov/last/rdy/busy/dout got %b%b%b%b %h want %b%b%b%b %h",
                   k, c, ov[k], lst[k], rdy[k], bsy[k], dout[k],
                   e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0]  a5;
    logic [7:0]  w4;
    logic [63:0] want;
    logic [63:0] got_beat [N][16];
    bit          got_last [N][16];
    int          got_n    [N];
    a5 = 8'hA5;
    w4 = 8'($urandom);
    for (int k = 0; k < N; k++) got_n[k] = 0;
    din[0] = 64'hA5;
    din[1] = 64'h0123456789ABCDEF;
    din[2] = 64'h0123456789ABCDEF;
    din[3] = 64'hE4;
    din[4] = {56'd0, w4};
    iv = '1;
    se = '1;
    for (int t = -1; t < 17; t++) begin
      if (t >= 0) begin
        iv = '0;
        se = '1;
        if (t == 1 || t == 2) se[3] = 1'b0;
      end
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if ({ov[k], lst[k], rdy[k], bsy[k], dout[k]} !==
            {e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]}) begin
          n_err++;
          $display("FAIL directed dut%0d t%0d: ov/last/rdy/busy/dout got %b%b%b%b %h want %b%b%b%b %h",
                   k, t, ov[k], lst[k], rdy[k], bsy[k], dout[k],
                   e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]);
        end
        if (ov[k] === 1'b1 && got_n[k] < 16) begin
          got_beat[k][got_n[k]] = dout[k];
          got_last[k][got_n[k]] = lst[k];
          got_n[k]++;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got_n[k] != beats(k)) begin
        n_err++;
        $display("FAIL directed_count dut%0d: got %0d beats want %0d", k, got_n[k], beats(k));
      end
      for (int i = 0; i < got_n[k]; i++) begin
        case (k)
          0:       want = 64'(a5[i]);
          1:       want = 64'(15 - i);
          4:       want = 64'(w4);
          default: want = 64'(i);
        endcase
        n_cmp++;
        if (got_beat[k][i] !== want || got_last[k][i] !== (i == beats(k) - 1)) begin
          n_err++;
          $display("FAIL directed_seq dut%0d beat%0d: got %h last=%b want %h last=%b",
                   k, i, got_beat[k][i], got_last[k][i], want, (i == beats(k) - 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int stage;
    bit want_ov, want_last;
    stage = 0;
    se = '1;
    for (int k = 1; k < N; k++) begin
      iv[k] = 1'b1;
      din[k] = {$urandom, $urandom};
    end
    iv[0] = 1'b1;
    din[0] = 64'hFF;
    for (int t = 0; t < 60; t++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if ({ov[k], lst[k], rdy[k], bsy[k], dout[k]} !==
            {e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]}) begin
          n_err++;
          $display("FAIL b2b dut%0d t%0d: ov/last/rdy/busy/dout got %b%b%b%b %h want %b%b%b%b %h",
                   k, t, ov[k], lst[k], rdy[k], bsy[k], dout[k],
                   e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]);
        end
      end
      if (t < 20) begin
        if (Pre) begin
          want_ov   = (t >= 1 && t <= 16);
          want_last = (t == 8 || t == 16);
        end else begin
          want_ov   = (t >= 1 && t <= 8) || (t >= 10 && t <= 17);
          want_last = (t == 8 || t == 17);
        end
        n_cmp++;
        if (ov[0] !== want_ov || lst[0] !== want_last || (want_ov && dout[0] !== 64'(t <= 8))) begin
          n_err++;
          $display("FAIL b2b_pattern t%0d: ov=%b last=%b dout=%h want ov=%b last=%b",
                   t, ov[0], lst[0], dout[0], want_ov, want_last);
        end
      end
      if (m_acc[0]) stage++;
      iv[0] = (stage < 2);
      din[0] = (stage == 0) ? 64'hFF : 64'h00;
      for (int k = 1; k < N; k++) begin
        if (t >= 40) begin
          iv[k] = 1'b0;
        end else if (m_acc[k]) begin
          din[k] = {$urandom, $urandom};
        end
      end
    end
  endtask

  task automatic test_random_stall();
    iv = '0;
    for (int t = 0; t < 700; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!(iv[k] && !m_acc[k])) begin
          iv[k]  = (t < 650) && ($urandom_range(0, 2) != 0);
          din[k] = {$urandom, $urandom};
        end
        se[k] = (t >= 650) || ($urandom_range(0, 3) != 0);
      end
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if ({ov[k], lst[k], rdy[k], bsy[k], dout[k]} !==
            {e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]}) begin
          n_err++;
          $display("FAIL random dut%0d t%0d: ov/last/rdy/busy/dout got %b%b%b%b %h want %b%b%b%b %h",
                   k, t, ov[k], lst[k], rdy[k], bsy[k], dout[k],
                   e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    for (int k = 0; k < N; k++) din[k] = {$urandom, $urandom};
    iv = '1;
    se = '1;
    for (int t = 0; t < 12; t++) begin
      if (t >= 1) iv = '0;
      rst_n = (t != 4);
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if ({ov[k], lst[k], rdy[k], bsy[k], dout[k]} !==
            {e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]}) begin
          n_err++;
          $display("FAIL midreset dut%0d t%0d: ov/last/rdy/busy/dout got %b%b%b%b %h want %b%b%b%b %h",
                   k, t, ov[k], lst[k], rdy[k], bsy[k], dout[k],
                   e_ov[k], e_last[k], e_rdy(k), m_busy[k], e_dout[k]);
        end
        if (t >= 4) begin
          n_cmp++;
          if (ov[k] !== 1'b0 || lst[k] !== 1'b0 || dout[k] !== 64'd0) begin
            n_err++;
            $display("FAIL midreset_quiet dut%0d t%0d: ov=%b last=%b dout=%h want 0 0 0",
                     k, t, ov[k], lst[k], dout[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stall();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
